// File: rtl/hack_mem_pkg.sv
// Shared Hack data-memory map constants and the arbiter ownership type.
package hack_mem_pkg;

   localparam int ADDR_W    = 15;
   localparam int DATA_W    = 16;
   localparam int SCREEN_AW = 13;

   localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
   localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_VID
   } owner_t;

   function automatic logic [ADDR_W-1:0] screen_addr(input logic [SCREEN_AW-1:0] offset);
      return SCREEN_BASE | {{(ADDR_W-SCREEN_AW){1'b0}}, offset};
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if;
   import hack_mem_pkg::*;

   logic                 cpu_req;
   logic                 cpu_we;
   logic [ADDR_W-1:0]    cpu_addr;
   logic [DATA_W-1:0]    cpu_wdata;
   logic                 cpu_gnt;
   logic                 cpu_rvalid;
   logic [DATA_W-1:0]    cpu_rdata;

   logic                 vid_req;
   logic [SCREEN_AW-1:0] vid_addr;
   logic                 vid_gnt;
   logic                 vid_rvalid;
   logic [DATA_W-1:0]    vid_rdata;

   logic [ADDR_W-1:0]    mem_address;
   logic [DATA_W-1:0]    mem_in;
   logic                 mem_load;
   logic [DATA_W-1:0]    mem_out;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_out,
      output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
             mem_address, mem_in, mem_load
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_out,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
             mem_address, mem_in, mem_load
   );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the display request has lost arbitration.
module starve_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [W-1:0] MAX_V = W'(MAX_WAIT);

   logic [W-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (clr) begin
         wait_cnt <= '0;
      end else if (inc && (wait_cnt != MAX_V)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // With MAX_WAIT = 0 the count never leaves zero, so display always wins.
   assign at_max = (wait_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// CPU/display arbiter for the single-ported Hack data memory: CPU has fixed priority,
// display is forced through after MAX_WAIT lost cycles; read data returns one cycle after grant.
module mem_arbiter
   import hack_mem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   owner_t              owner;
   owner_t              last_owner;
   logic                last_rd;
   logic                at_max;
   logic [ADDR_W-1:0]   address;
   logic [DATA_W-1:0]   wdata;
   logic                load;
   logic [DATA_W-1:0]   cpu_rdata;
   logic [DATA_W-1:0]   vid_rdata;

   // Reset gates ownership combinationally so grants and load drop at once.
   always_comb begin
      owner = OWN_NONE;
      if (!rst_n) begin
         owner = OWN_NONE;
      end else if (bus.vid_req && (!bus.cpu_req || at_max)) begin
         owner = OWN_VID;
      end else if (bus.cpu_req) begin
         owner = OWN_CPU;
      end
   end

   always_comb begin
      address = '0;
      wdata   = '0;
      load    = 1'b0;
      case (owner)
         OWN_CPU: begin
            address = bus.cpu_addr;
            wdata   = bus.cpu_wdata;
            load    = bus.cpu_we;
         end
         OWN_VID: begin
            address = screen_addr(bus.vid_addr);
         end
         default: ;
      endcase
   end

   starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (bus.vid_req && (owner != OWN_VID)),
      .clr    (!bus.vid_req || (owner == OWN_VID)),
      .at_max (at_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= OWN_NONE;
         last_rd    <= 1'b0;
         cpu_rdata  <= '0;
         vid_rdata  <= '0;
      end else begin
         last_owner <= owner;
         case (owner)
            OWN_CPU: begin
               last_rd <= !bus.cpu_we;
               if (!bus.cpu_we) begin
                  cpu_rdata <= bus.mem_out;
               end
            end
            OWN_VID: begin
               last_rd   <= 1'b1;
               vid_rdata <= bus.mem_out;
            end
            default: last_rd <= 1'b0;
         endcase
      end
   end

   assign bus.cpu_gnt     = (owner == OWN_CPU);
   assign bus.vid_gnt     = (owner == OWN_VID);
   assign bus.mem_address = address;
   assign bus.mem_in      = wdata;
   assign bus.mem_load    = load;
   assign bus.cpu_rvalid  = (last_owner == OWN_CPU) && last_rd;
   assign bus.vid_rvalid  = (last_owner == OWN_VID) && last_rd;
   assign bus.cpu_rdata   = cpu_rdata;
   assign bus.vid_rdata   = vid_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: MAX_WAIT=4 and MAX_WAIT=0 instances share stimulus, each with its own memory.
module tb_mem_arbiter;
   import hack_mem_pkg::*;

   localparam logic [15:0] KBD_VAL = 16'h0041;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus0();
   mem_arbiter_if bus1();

   mem_arbiter #(.MAX_WAIT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   mem_arbiter #(.MAX_WAIT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic        cr, cw, vr;
   logic [14:0] ca;
   logic [15:0] cd;
   logic [12:0] va;

   assign bus0.cpu_req = cr;  assign bus1.cpu_req = cr;
   assign bus0.cpu_we = cw;   assign bus1.cpu_we = cw;
   assign bus0.cpu_addr = ca; assign bus1.cpu_addr = ca;
   assign bus0.cpu_wdata = cd; assign bus1.cpu_wdata = cd;
   assign bus0.vid_req = vr;  assign bus1.vid_req = vr;
   assign bus0.vid_addr = va; assign bus1.vid_addr = va;

   // Physical memories seen by each DUT: RAM + screen below KBD, keyboard word, zero elsewhere.
   logic [15:0] env0 [0:32767];
   logic [15:0] env1 [0:32767];

   always_comb begin
      if (bus0.mem_address < KBD_ADDR)       bus0.mem_out = env0[bus0.mem_address];
      else if (bus0.mem_address == KBD_ADDR) bus0.mem_out = KBD_VAL;
      else                                   bus0.mem_out = 16'h0000;
   end
   always_comb begin
      if (bus1.mem_address < KBD_ADDR)       bus1.mem_out = env1[bus1.mem_address];
      else if (bus1.mem_address == KBD_ADDR) bus1.mem_out = KBD_VAL;
      else                                   bus1.mem_out = 16'h0000;
   end
   always @(posedge clk) begin
      if (bus0.mem_load && bus0.mem_address < KBD_ADDR) env0[bus0.mem_address] <= bus0.mem_in;
      if (bus1.mem_load && bus1.mem_address < KBD_ADDR) env1[bus1.mem_address] <= bus1.mem_in;
   end

   // Observed outputs, index 0 = MAX_WAIT 4, index 1 = MAX_WAIT 0.
   logic [1:0]       a_cg, a_vg, a_ld, a_crv, a_vrv;
   logic [1:0][14:0] a_addr;
   logic [1:0][15:0] a_din, a_crd, a_vrd;
   assign a_cg   = {bus1.cpu_gnt, bus0.cpu_gnt};
   assign a_vg   = {bus1.vid_gnt, bus0.vid_gnt};
   assign a_ld   = {bus1.mem_load, bus0.mem_load};
   assign a_crv  = {bus1.cpu_rvalid, bus0.cpu_rvalid};
   assign a_vrv  = {bus1.vid_rvalid, bus0.vid_rvalid};
   assign a_addr = {bus1.mem_address, bus0.mem_address};
   assign a_din  = {bus1.mem_in, bus0.mem_in};
   assign a_crd  = {bus1.cpu_rdata, bus0.cpu_rdata};
   assign a_vrd  = {bus1.vid_rdata, bus0.vid_rdata};

   typedef struct packed {
      logic [1:0]       cg, vg, ld, crv, vrv;
      logic [1:0][14:0] addr;
      logic [1:0][15:0] din, crd, vrd;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   // Reference model state
   logic [15:0] refm [0:1][0:32767];
   int          losses [2];
   logic        pend_crv [2], pend_vrv [2];
   logic [15:0] pend_crd [2], pend_vrd [2], cur_crd [2], cur_vrd [2];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s (max_wait=%0d) at %0t: got %h want %h", name, (k == 0) ? 4 : 0, $time, act, want);
      end
   endtask

   function automatic logic [15:0] ref_rd(input int k, input logic [14:0] a);
      if (a < KBD_ADDR) return refm[k][a];
      if (a == KBD_ADDR) return KBD_VAL;
      return 16'h0000;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         losses[k] = 0;
         pend_crv[k] = 1'b0; pend_vrv[k] = 1'b0;
         pend_crd[k] = '0;   pend_vrd[k] = '0;
         cur_crd[k] = '0;    cur_vrd[k] = '0;
      end
   endtask

   task automatic check_reset(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, " cpu_gnt"}, k, 32'(a_cg[k]), 0);
         chk({tag, " vid_gnt"}, k, 32'(a_vg[k]), 0);
         chk({tag, " mem_load"}, k, 32'(a_ld[k]), 0);
         chk({tag, " mem_address"}, k, 32'(a_addr[k]), 0);
         chk({tag, " mem_in"}, k, 32'(a_din[k]), 0);
         chk({tag, " cpu_rvalid"}, k, 32'(a_crv[k]), 0);
         chk({tag, " vid_rvalid"}, k, 32'(a_vrv[k]), 0);
         chk({tag, " cpu_rdata"}, k, 32'(a_crd[k]), 0);
         chk({tag, " vid_rdata"}, k, 32'(a_vrd[k]), 0);
      end
   endtask

   // Drive one cycle of inputs, predict both arbiters, then advance to just after the edge.
   task automatic cycle(input logic i_cr, input logic i_cw, input logic [14:0] i_ca, input logic [15:0] i_cd,
                        input logic i_vr, input logic [12:0] i_va, output logic c_done, output logic v_done);
      exp_t e;
      logic vwin, cwin;
      int   mw;
      logic [14:0] vaddr;
      cr = i_cr; cw = i_cw; ca = i_ca; cd = i_cd; vr = i_vr; va = i_va;
      e = '0;
      c_done = 1'b0;
      v_done = 1'b0;
      vaddr = SCREEN_BASE + 15'(i_va);
      for (int k = 0; k < 2; k++) begin
         mw   = (k == 0) ? 4 : 0;
         vwin = i_vr && (!i_cr || losses[k] >= mw);
         cwin = i_cr && !vwin;
         e.cg[k]   = cwin;
         e.vg[k]   = vwin;
         e.addr[k] = cwin ? i_ca : (vwin ? vaddr : 15'h0000);
         e.din[k]  = cwin ? i_cd : 16'h0000;
         e.ld[k]   = cwin && i_cw;
         e.crv[k]  = pend_crv[k];
         e.vrv[k]  = pend_vrv[k];
         if (pend_crv[k]) cur_crd[k] = pend_crd[k];
         if (pend_vrv[k]) cur_vrd[k] = pend_vrd[k];
         e.crd[k] = cur_crd[k];
         e.vrd[k] = cur_vrd[k];
         pend_crv[k] = cwin && !i_cw;
         if (pend_crv[k]) pend_crd[k] = ref_rd(k, i_ca);
         pend_vrv[k] = vwin;
         if (vwin) pend_vrd[k] = ref_rd(k, vaddr);
         if (cwin && i_cw && i_ca < KBD_ADDR) refm[k][i_ca] = i_cd;
         losses[k] = (i_vr && !vwin) ? ((losses[k] < mw) ? losses[k] + 1 : mw) : 0;
         if (k == 0) begin
            c_done = cwin;
            v_done = vwin;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each predicted cycle against the DUTs away from the clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 2; k++) begin
               chk("cpu_gnt", k, 32'(a_cg[k]), 32'(e.cg[k]));
               chk("vid_gnt", k, 32'(a_vg[k]), 32'(e.vg[k]));
               chk("mem_address", k, 32'(a_addr[k]), 32'(e.addr[k]));
               chk("mem_in", k, 32'(a_din[k]), 32'(e.din[k]));
               chk("mem_load", k, 32'(a_ld[k]), 32'(e.ld[k]));
               chk("cpu_rvalid", k, 32'(a_crv[k]), 32'(e.crv[k]));
               chk("cpu_rdata", k, 32'(a_crd[k]), 32'(e.crd[k]));
               chk("vid_rvalid", k, 32'(a_vrv[k]), 32'(e.vrv[k]));
               chk("vid_rdata", k, 32'(a_vrd[k]), 32'(e.vrd[k]));
            end
         end
      end
   end

   function automatic logic [14:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 15'($urandom_range(0, 15));
         1:       return SCREEN_BASE + 15'($urandom_range(0, 15));
         2:       return KBD_ADDR;
         default: return KBD_ADDR + 15'($urandom_range(1, 16'h1FFF));
      endcase
   endfunction

   initial begin
      logic        cdn, vdn;
      logic        c_act, c_we_r, v_act;
      logic [14:0] c_addr_r;
      logic [15:0] c_wd_r, v;
      logic [12:0] v_addr_r;

      for (int a = 0; a < 32768; a++) begin
         v = 16'(a * 7) ^ 16'h5A5A;
         env0[a] = v; env1[a] = v;
         refm[0][a] = v; refm[1][a] = v;
      end
      cr = 0; cw = 0; ca = '0; cd = '0; vr = 0; va = '0;
      model_reset();
      #3;
      check_reset("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      cycle(1, 1, 15'h0010, 16'hBEEF, 0, 13'h0, cdn, vdn);
      cycle(1, 0, 15'h0010, 16'h0000, 0, 13'h0, cdn, vdn);
      cycle(0, 0, 15'h0000, 16'h0000, 1, 13'h0005, cdn, vdn);
      cycle(1, 0, KBD_ADDR, 16'h0000, 0, 13'h0, cdn, vdn);
      cycle(0, 0, 15'h0000, 16'h0000, 0, 13'h0, cdn, vdn);
      repeat (7) cycle(1, 0, 15'h0020, 16'h0000, 1, 13'h0007, cdn, vdn);
      repeat (3) cycle(1, 1, 15'h4003, 16'h1234, 1, 13'h0003, cdn, vdn);
      cycle(0, 0, 15'h0000, 16'h0000, 0, 13'h0, cdn, vdn);
      cycle(1, 0, 15'h0010, 16'h0000, 0, 13'h0, cdn, vdn);

      // Reset pulse in the middle of an uncontested CPU write
      cr = 1; cw = 1; ca = 15'h0003; cd = 16'hDEAD; vr = 0; va = '0;
      #2;
      for (int k = 0; k < 2; k++) chk("pre-reset mem_load", k, 32'(a_ld[k]), 1);
      rst_n = 1'b0;
      #1;
      check_reset("mid-reset");
      @(posedge clk); #1;
      chk("write blocked in reset", 0, 32'(env0[3]), 32'(refm[0][3]));
      chk("write blocked in reset", 1, 32'(env1[3]), 32'(refm[1][3]));
      cr = 0; cw = 0; ca = '0; cd = '0;
      model_reset();
      rst_n = 1'b1;

      c_act = 0; v_act = 0; c_we_r = 0; c_addr_r = '0; c_wd_r = '0; v_addr_r = '0;
      for (int i = 0; i < 800; i++) begin
         if (!c_act && $urandom_range(0, 9) < 6) begin
            c_act = 1; c_we_r = 1'($urandom_range(0, 1));
            c_addr_r = pick_addr(); c_wd_r = 16'($urandom);
         end
         if (!v_act && $urandom_range(0, 1) == 1) begin
            v_act = 1; v_addr_r = 13'($urandom_range(0, 15));
         end
         if (c_act && $urandom_range(0, 19) == 0) c_act = 0;
         if (v_act && $urandom_range(0, 19) == 0) v_act = 0;
         if (c_act)
            cycle(1, c_we_r, c_addr_r, c_wd_r, v_act, v_act ? v_addr_r : 13'($urandom), cdn, vdn);
         else
            cycle(0, 1'($urandom), 15'($urandom), 16'($urandom), v_act, v_act ? v_addr_r : 13'($urandom), cdn, vdn);
         if (cdn) c_act = 0;
         if (vdn) v_act = 0;
      end
      repeat (3) cycle(0, 0, 15'h0000, 16'h0000, 0, 13'h0, cdn, vdn);

      chk("scoreboard drained", 0, 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported Hack data memory (RAM16K + screen + keyboard map) between the CPU data port and the display refresh engine. Sits between both requesters and the `memory` block: drives its `address`, `in` and `load`, and returns its `out` to the winning requester one cycle later. CPU has fixed priority. A starvation counter guarantees the display port a grant within `MAX_WAIT` cycles.

## Interface
- `MAX_WAIT`, 4: max consecutive cycles a pending display request may lose before it is forced to win. 0 = display always wins.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 15: full Hack data address.
- `cpu_wdata` in 16: write data.
- `cpu_gnt` out 1: CPU owns memory this cycle.
- `cpu_rvalid` out 1: `cpu_rdata` valid, one cycle after a read grant.
- `cpu_rdata` out 16: registered read data.
- `vid_req` in 1: display read request.
- `vid_addr` in 13: screen word offset.
- `vid_gnt` out 1: display owns memory this cycle.
- `vid_rvalid` out 1: `vid_rdata` valid.
- `vid_rdata` out 16: registered read data.
- `mem_address` out 15: to memory `address`.
- `mem_in` out 16: to memory `in`.
- `mem_load` out 1: to memory `load`.
- `mem_out` in 16: from memory `out`; combinational read.

## Operation
- Owner is decided combinationally each cycle from the requests and `wait_cnt`:
  - VID if `vid_req` and (`!cpu_req` or `wait_cnt == MAX_WAIT`).
  - Else CPU if `cpu_req`.
  - Else NONE.
- The registered state `last_owner` ∈ {NONE, CPU, VID} records the previous cycle's owner and selects which `*_rvalid`/`*_rdata` is loaded.
- Grants: `cpu_gnt = (owner==CPU)`, `vid_gnt = (owner==VID)`. Both are forced to 0 while `rst_n` is low. The two grants are never both 1.
- Memory drive:
  - CPU owner: `mem_address = cpu_addr`, `mem_in = cpu_wdata`, `mem_load = cpu_we`.
  - VID owner: `mem_address = SCREEN_BASE | vid_addr`, `mem_in = 0`, `mem_load = 0`.
  - NONE: all outputs 0.
- Transfer occurs at a rising edge where `req && gnt`. The requester holds `req`, address, `we` and data stable until then. Dropping `req` before the grant withdraws the request with no side effects.
- `wait_cnt`:
  - Width `$clog2(MAX_WAIT+1)`, minimum 1.
  - Increments when `vid_req && !vid_gnt`, saturating at `MAX_WAIT`.
  - Clears on a VID grant or when `vid_req` is low.
- Write grants produce no rvalid. Read grants capture `mem_out` into the owner's `rdata` at the edge and set its `rvalid` for exactly the next cycle.
- `rdata` holds its value when `rvalid` is low.
- Keyboard address (0x6000) and unmapped addresses pass through unchanged; `memory` defines the returned data.

## Timing
- Grant latency: 0 cycles (same cycle as req) when uncontested.
- Read latency: rvalid/rdata 1 cycle after the granting edge. Back-to-back grants give one rvalid per cycle.
- Write commits at the granting edge.
- Worst-case display wait: `MAX_WAIT` cycles of continuous CPU requests, then a grant on the next cycle.
- Reset values:
  - `cpu_gnt`, `vid_gnt`, `cpu_rvalid`, `vid_rvalid`, `mem_load`: 0.
  - `cpu_rdata`, `vid_rdata`: 16'h0000.
  - `mem_address`, `mem_in`: 0.
  - `wait_cnt`: 0. `last_owner`: NONE.
- Reset asserted mid-access: grants and `mem_load` drop immediately (asynchronously). Any pending rvalid is discarded. No write occurs at an edge while `rst_n` is low.
- After `rst_n` deasserts, arbitration resumes at the first edge.

## Structure
- Shared package `hack_mem_pkg`:
  - `SCREEN_BASE = 15'h4000`, `KBD_ADDR = 15'h6000`.
  - `ADDR_W = 15`, `DATA_W = 16`, `SCREEN_AW = 13`.
  - Enum `owner_t` {OWN_NONE, OWN_CPU, OWN_VID}.
- One sub-module, `starve_counter`: saturating up-counter with `inc`/`clr`/`at_max` ports, parameterised by `MAX_WAIT`.

## Test plan
- CPU write 16'hBEEF to 15'h0010, then read 15'h0010 → `mem_load` = 1 only on the write cycle; `cpu_rvalid` = 1 one cycle after the read grant, with `cpu_rdata` = 16'hBEEF.
- Display read alone, `vid_addr` = 13'h0005 → `mem_address` = 15'h4005, `vid_gnt` same cycle, `vid_rvalid` next cycle with the screen word.
- `cpu_req` held continuously with `vid_req` high, `MAX_WAIT` = 4 → CPU granted 4 cycles, VID granted on cycle 5, CPU again on cycle 6; `wait_cnt` returns to 0.
- Simultaneous requests with `MAX_WAIT` = 0 → VID wins every contested cycle, CPU only when `vid_req` is low.
- `rst_n` pulsed low during a CPU write grant → `mem_load` drops immediately, memory at the target address unchanged, all outputs at reset values.
- CPU read of 15'h6000 → `mem_address` = 15'h6000, `mem_load` = 0, `cpu_rvalid` the next cycle.
